apple_placer: RTL

APPLE_PLACER -- requirements
Module: apple_placer

---
 rtl/apple_placer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/apple_placer.sv
// Apple placer: draws a pseudo-random cell from a 16-bit LFSR and places an apple there if the cell is empty.
// Optional feature macro APPLE_RETRY_EN: retry up to 4 candidates before declaring the field full.
module apple_placer #(
   parameter logic [7:0] SIZE_X = 8'd10,
   parameter logic [7:0] SIZE_Y = 8'd10,
   localparam int FIELD_SIZE = int'(SIZE_X) * int'(SIZE_Y),
   localparam int FIELD_BITS = FIELD_SIZE * 3,
   localparam int SBITS      = $clog2(FIELD_SIZE),
   localparam int POSBITS    = $clog2(FIELD_BITS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [FIELD_BITS-1:0] field,
   output logic [SBITS-1:0]      seed,
   input  logic [POSBITS-1:0]    apple_pos,
   output logic                  busy,
   output logic                  place_valid,
   output logic [POSBITS-1:0]    place_pos,
   output logic                  field_full
);

   typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;

   state_t            state, state_next;
   logic [15:0]       lfsr;
   logic              lfsr_fb;
   logic [SBITS-1:0]  cand;
   logic [SBITS-1:0]  cand_reduced;
   logic              cell_empty;
   logic              load_seed;
   logic              accept;
   logic              do_place;
   logic              do_full;

   // Taps 16,14,13,11 of the polynomial map to bits 0,2,3,5 in the right-shifting form.
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   // The raw candidate is below 2*FIELD_SIZE, so a single subtraction keeps the seed in range.
   assign cand         = lfsr[SBITS-1:0];
   assign cand_reduced = ({1'b0, cand} >= (SBITS+1)'(FIELD_SIZE)) ? (cand - SBITS'(FIELD_SIZE)) : cand;

   assign cell_empty = (field[apple_pos +: 3] == 3'd0);
   assign busy       = (state == EVAL);

`ifdef APPLE_RETRY_EN
   logic [1:0] retry_cnt;
   logic       do_retry;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_seed  = 1'b0;
      accept     = 1'b0;
      do_place   = 1'b0;
      do_full    = 1'b0;
`ifdef APPLE_RETRY_EN
      do_retry   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (req) begin
               accept     = 1'b1;
               load_seed  = 1'b1;
               state_next = EVAL;
            end
         end
         EVAL: begin
            if (cell_empty) begin
               do_place   = 1'b1;
               state_next = IDLE;
            end else begin
`ifdef APPLE_RETRY_EN
               if (retry_cnt == 2'd3) begin
                  do_full    = 1'b1;
                  state_next = IDLE;
               end else begin
                  do_retry  = 1'b1;
                  load_seed = 1'b1;
               end
`else
               do_full    = 1'b1;
               state_next = IDLE;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr        <= 16'hACE1;
         seed        <= '0;
         place_valid <= 1'b0;
         place_pos   <= '0;
         field_full  <= 1'b0;
      end else begin
         lfsr        <= {lfsr_fb, lfsr[15:1]};
         place_valid <= do_place;
         if (load_seed) seed <= cand_reduced;
         if (do_place)  place_pos <= apple_pos;
         if (do_full)     field_full <= 1'b1;
         else if (accept) field_full <= 1'b0;
      end
   end

`ifdef APPLE_RETRY_EN
   // Counts failed evaluations of the current request; any exit from EVAL or new request restarts it.
   always_ff @(posedge clk) begin
      if (reset)                            retry_cnt <= 2'd0;
      else if (accept || do_place || do_full) retry_cnt <= 2'd0;
      else if (do_retry)                    retry_cnt <= retry_cnt + 2'd1;
   end
`endif

endmodule
